// File: rtl/read_resp_assembler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : read_resp_assembler
// Purpose  : Packs BURST_LEN backend read beats into one line, tags it with the
//            ID FIFO head and returns it in order; optional RD_RESP_TIMEOUT_EN.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module read_resp_assembler #(
  parameter int ID_WIDTH    = 5,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [ID_WIDTH-1:0]              i_fifo_data,
  input  logic                             i_fifo_empty,
  output logic                             o_fifo_rd_en,
  input  logic                             i_rdata_valid,
  input  logic [DATA_WIDTH-1:0]            i_rdata,
  output logic                             o_rdata_ready,
  output logic                             o_resp_valid,
  input  logic                             i_resp_ready,
  output logic [ID_WIDTH-1:0]              o_resp_id,
  output logic [DATA_WIDTH*BURST_LEN-1:0]  o_resp_data,
  output logic                             o_orphan_err
`ifdef RD_RESP_TIMEOUT_EN
  ,
  output logic                             o_timeout_err
`endif
);

  localparam int               c_cnt_w     = $clog2(BURST_LEN) + 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_collect = 2'd1;
  localparam logic [1:0] c_send    = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_beat [BURST_LEN];
  logic                  r_orphan_err;
  logic                  w_beat_acc;
  logic                  w_timeout;

  assign w_beat_acc = i_rdata_valid && o_rdata_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= c_idle;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:    if (w_beat_acc) w_next_state = (BURST_LEN == 1) ? c_send : c_collect;
      c_collect: if ((w_beat_acc && (r_cnt == c_last_beat)) || w_timeout) w_next_state = c_send;
      c_send:    if (i_resp_ready) w_next_state = c_idle;
      default:   w_next_state = c_idle;
    endcase
  end

  // Ready is gated by reset so the beat handshake is closed while reset is held.
  always_comb begin
    o_rdata_ready = 1'b0;
    o_resp_valid  = 1'b0;
    o_fifo_rd_en  = 1'b0;
    case (r_state)
      c_idle:    o_rdata_ready = !i_fifo_empty && i_rst_n;
      c_collect: o_rdata_ready = 1'b1;
      c_send: begin
        o_resp_valid = 1'b1;
        o_fifo_rd_en = i_resp_ready && !i_fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_cnt <= '0;
    else if (w_timeout)   r_cnt <= '0;
    else if (w_beat_acc)  r_cnt <= (r_cnt == c_last_beat) ? '0 : r_cnt + 1'b1;
  end

  // The first beat of a burst clears the rest of the line so a timed-out burst
  // returns zeros in the beats that never arrived.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < BURST_LEN; k++) r_beat[k] <= '0;
    end else if (w_beat_acc) begin
      for (int k = 0; k < BURST_LEN; k++) begin
        if (r_state == c_idle)             r_beat[k] <= (k == 0) ? i_rdata : '0;
        else if (r_cnt == c_cnt_w'(k))     r_beat[k] <= i_rdata;
      end
    end
  end

  generate
    for (genvar g = 0; g < BURST_LEN; g++) begin : g_pack
      assign o_resp_data[g*DATA_WIDTH +: DATA_WIDTH] = r_beat[g];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_orphan_err <= 1'b0;
    else if ((r_state == c_idle) && i_rdata_valid && i_fifo_empty) r_orphan_err <= 1'b1;
  end

  assign o_orphan_err = r_orphan_err;
  assign o_resp_id    = i_fifo_data;

`ifdef RD_RESP_TIMEOUT_EN
  localparam int c_idle_w = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [c_idle_w-1:0] r_idle_cnt;
  logic                r_timeout_err;

  // An arriving beat always wins over an expiring timeout in the same cycle.
  assign w_timeout = (r_state == c_collect) && !w_beat_acc &&
                     (r_idle_cnt == c_idle_w'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state != c_collect) || w_beat_acc || w_timeout) r_idle_cnt <= '0;
      else                                                   r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
